// File: rtl/deint_frame_ctrl.sv
// deint_frame_ctrl
//   Receive-side sequencer for an n x symbol_num block deinterleaver.
//   It collects a serial bit stream into a frame register. It then pulses de_en
//   for one cycle so the deinterleaver captures the frame. After that it drains
//   the deinterleaved frame as symbol_num n-bit codewords over valid/ready.
//   Collection of the next frame overlaps the drain of the current one.
//
//   Optional build macro DEINT_FRAME_CTRL_STATS_EN adds the frame_cnt and
//   stall_cnt statistic outputs.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_bit    serial input bit and its valid flag
//   in_ready            controller can accept in_bit
//   de_en               one-cycle load strobe to the deinterleaver
//   de_frame            frame register; bit 0 is the first bit received
//   de_data             deinterleaved frame returned by the deinterleaver
//   cw_valid, cw_data   codeword handshake towards the decoder
//   cw_last, cw_ready   last codeword of the frame, downstream ready
//   busy                a partial frame is held or the FSM is not IDLE
//   frame_cnt           (stats) frames drained, wraps
//   stall_cnt           (stats) cycles with in_valid && !in_ready, saturates
module deint_frame_ctrl #(
  parameter int n          = 7,
  parameter int symbol_num = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_bit,
  output logic                      in_ready,
  output logic                      de_en,
  output logic [n*symbol_num-1:0]   de_frame,
  input  logic [n*symbol_num-1:0]   de_data,
  output logic                      cw_valid,
  output logic [n-1:0]              cw_data,
  output logic                      cw_last,
  input  logic                      cw_ready,
  output logic                      busy
`ifdef DEINT_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int F  = n * symbol_num;
  localparam int CW = $clog2(F + 1);
  localparam int IW = (symbol_num > 1) ? $clog2(symbol_num) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            fill_full;
  logic [F-1:0]    fill;
  logic [IW-1:0]   idx;

  logic accept;
  logic last_bit;
  logic full_next;
  logic hs;
  logic last_idx;

  assign in_ready  = rst_n && !fill_full;
  assign accept    = in_valid && in_ready;
  assign last_bit  = accept && (cnt == CW'(F - 1));
  // The last bit arriving this edge counts as full, so the load strobe lands
  // in the very next cycle.
  assign full_next = fill_full || last_bit;
  assign hs        = cw_valid && cw_ready;
  assign last_idx  = (idx == IW'(symbol_num - 1));

  assign de_frame = fill;
  assign busy     = (cnt != '0) || (state != IDLE);
  assign cw_data  = cw_valid ? de_data[int'(idx)*n +: n] : '0;
  assign cw_last  = cw_valid && last_idx;

  // Fill path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      fill_full <= 1'b0;
      fill      <= '0;
    end else if (accept) begin
      fill[cnt] <= in_bit;
      if (last_bit) begin
        cnt       <= '0;
        fill_full <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (state == LOAD) begin
      fill_full <= 1'b0;
    end
  end

  // Load / drain sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      de_en    <= 1'b0;
      cw_valid <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (full_next) begin
            state <= LOAD;
            de_en <= 1'b1;
          end
        end
        LOAD: begin
          de_en    <= 1'b0;
          idx      <= '0;
          cw_valid <= 1'b1;
          state    <= DRAIN;
        end
        DRAIN: begin
          if (hs) begin
            if (last_idx) begin
              cw_valid <= 1'b0;
              idx      <= '0;
              if (full_next) begin
                state <= LOAD;
                de_en <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          de_en    <= 1'b0;
          cw_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEINT_FRAME_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (hs && last_idx)
        frame_cnt <= frame_cnt + 16'd1;
      if (in_valid && !in_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_deint_frame_ctrl.sv
// Testbench for deint_frame_ctrl. It includes a behavioural block
// deinterleaver. Expected codewords are pushed to a queue when a frame is
// driven and popped on every codeword handshake.
module tb_deint_frame_ctrl;

  localparam int N = 7;
  localparam int S = 5;
  localparam int F = N * S;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_bit, in_ready;
  logic          de_en;
  logic [F-1:0]  de_frame, de_data, de_reg;
  logic          cw_valid, cw_last, cw_ready;
  logic [N-1:0]  cw_data;
  logic          busy;
`ifdef DEINT_FRAME_CTRL_STATS_EN
  logic [15:0]   frame_cnt, stall_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  sb [$];

  always #5 clk = ~clk;

  deint_frame_ctrl #(.n(N), .symbol_num(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .de_en    (de_en),
    .de_frame (de_frame),
    .de_data  (de_data),
    .cw_valid (cw_valid),
    .cw_data  (cw_data),
    .cw_last  (cw_last),
    .cw_ready (cw_ready),
    .busy     (busy)
`ifdef DEINT_FRAME_CTRL_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  // Block deinterleaver: written in rows of S bits, read out in columns of N bits.
  function automatic logic [F-1:0] deint(input logic [F-1:0] x);
    logic [F-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < S; j++)
        r[j*N + i] = x[i*S + j];
    return r;
  endfunction

  initial de_reg = '0;
  always @(posedge clk) if (de_en) de_reg <= deint(de_frame);
  assign de_data = de_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s got timeout want event", tag);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!cw_valid)
      check("cw_idle_zero", {cw_last, cw_data}, 32'd0);
    check("de_en_in_drain", de_en & cw_valid, 32'd0);
    if (rst_n && cw_valid && cw_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cw_unexpected got %h want none", {cw_last, cw_data});
      end else begin
        check("cw", {cw_last, cw_data}, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [F-1:0] bits, input int unsigned nb, input bit push);
    logic [F-1:0] d;
    bit acc;
    int unsigned w;
    if (push) begin
      d = deint(bits);
      for (int j = 0; j < S; j++)
        sb.push_back({(j == S-1) ? 1'b1 : 1'b0, d[j*N +: N]});
    end
    for (int unsigned k = 0; k < nb; k++) begin
      in_valid = 1'b1;
      in_bit   = bits[k];
      w = 0;
      forever begin
        acc = in_ready;
        step();
        if (acc) break;
        w++;
        if (w > 200) begin
          timeout_fail("send_ready");
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int unsigned c = 0; c < 300; c++) begin
      step();
      if (sb.size() == 0 && !cw_valid) return;
    end
    timeout_fail(tag);
  endtask

  task automatic wait_ready(input string tag);
    for (int unsigned c = 0; c < 50; c++) begin
      if (in_ready) return;
      step();
    end
    timeout_fail(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    sb.delete();
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [F-1:0] rnd_frame();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[F-1:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [F-1:0] f;
    logic [F-1:0] fb;
    bit hit;
    bit seen;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    cw_ready = 1'b1;
    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_de_en",    de_en,    0);
    check("rst_cw_valid", cw_valid, 0);
    check("rst_cw_last",  cw_last,  0);
    check("rst_cw_data",  cw_data,  0);
    check("rst_busy",     busy,     0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Single set bit at index 5 lands in codeword 0 bit 1.
    f = '0;
    f[5] = 1'b1;
    send(f, F, 1);
    check("t1_de_en_T1",    de_en,    1);
    check("t1_cw_valid_T1", cw_valid, 0);
    check("t1_busy",        busy,     1);
    step();
    check("t1_de_en_T2",    de_en,    0);
    check("t1_cw_valid_T2", cw_valid, 1);
    check("t1_cw0",         cw_data,  7'h02);
    wait_drain("t1_drain");

    // Index 1 lands in codeword 1 bit 0.
    f = '0;
    f[1] = 1'b1;
    send(f, F, 1);
    wait_drain("t2_drain");

    // All ones, downstream stalls for 10 cycles.
    cw_ready = 1'b0;
    f = '1;
    send(f, F, 1);
    step();
    for (int c = 0; c < 10; c++) begin
      check("t3_hold_valid", cw_valid, 1);
      check("t3_hold_data",  cw_data,  7'h7F);
      check("t3_hold_last",  cw_last,  0);
      check("t3_no_de_en",   de_en,    0);
      step();
    end
    cw_ready = 1'b1;
    wait_drain("t3_drain");

    // Two frames back to back while the first drain is stalled.
    cw_ready = 1'b0;
    f  = rnd_frame();
    fb = rnd_frame();
    send(f, F, 1);
    send(fb, F, 1);
    check("t4_in_ready_drop", in_ready, 0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    repeat (4) step();
    in_valid = 1'b0;
    check("t4_in_ready_held", in_ready, 0);
    cw_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      hit = cw_valid && cw_ready && cw_last;
      step();
      if (hit) begin
        check("t4_de_en_after_last", de_en, 1);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout_fail("t4_last_hs");
    wait_drain("t4_drain");

    // Reset mid-frame.
    send(rnd_frame(), 20, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_de_en",    de_en,    0);
    check("t5_rst_cw_valid", cw_valid, 0);
    check("t5_rst_cw_data",  cw_data,  0);
    check("t5_rst_cw_last",  cw_last,  0);
    check("t5_rst_busy",     busy,     0);
    do_reset();
    send(rnd_frame(), F, 1);
    wait_drain("t5_drain");

    // Reset mid-drain.
    cw_ready = 1'b0;
    send(rnd_frame(), F, 1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_cw_valid", cw_valid, 0);
    check("t6_rst_busy",     busy,     0);
    do_reset();
    cw_ready = 1'b1;
    send(rnd_frame(), F, 1);
    wait_drain("t6_drain");
    check("t6_idle_busy", busy, 0);

`ifdef DEINT_FRAME_CTRL_STATS_EN
    do_reset();
    check("st_frame_cnt_rst", frame_cnt, 0);
    check("st_stall_cnt_rst", stall_cnt, 0);
    cw_ready = 1'b0;
    send(rnd_frame(), F, 1);
    wait_ready("st_ready1");
    send(rnd_frame(), F, 1);
    in_valid = 1'b1;
    in_bit   = 1'b0;
    repeat (4) step();
    in_valid = 1'b0;
    cw_ready = 1'b1;
    wait_drain("st_drain12");
    wait_ready("st_ready3");
    send(rnd_frame(), F, 1);
    wait_drain("st_drain3");
    check("st_frame_cnt", frame_cnt, 3);
    check("st_stall_cnt", stall_cnt, 4);
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
